pc_sequencer: RTL

Next-PC sequencer for the single-cycle MIPS core: owns the program counter register and decides each cycle whether the core fetches sequentially, follows a branch, jump or register jump, holds on a stall, or redirects to the exception vector. It sits between the control unit and the instruction memory address port. It replaces the bare PC register plus the external next-PC muxes. A small boot FSM guarantees a defined fetch start after reset.

---
 rtl/pc_seq_pkg.sv | 20 ++
 rtl/pc_target_calc.sv | 16 +
 rtl/pc_sequencer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and default vectors for the next-PC sequencer.
// State set depends on PC_SEQ_EXC_EN (TRAP only exists when exceptions are built in).
package pc_seq_pkg;

   localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
   localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_0080;

`ifdef PC_SEQ_EXC_EN
   typedef enum logic [1:0] {BOOT, RUN, TRAP} state_t;
`else
   typedef enum logic [1:0] {BOOT, RUN} state_t;
`endif

   typedef enum logic [2:0] {SEQ, HOLD, BR, J, JR, EXC, ERET} src_t;

   function automatic logic is_misaligned(input logic [1:0] addr_lsb);
      return |addr_lsb;
   endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-PC candidates: sequential, branch and jump targets.
module pc_target_calc (
   input  logic [31:0] pc,
   input  logic [31:0] branch_off,
   input  logic [25:0] jump_idx,
   output logic [31:0] pc_plus4,
   output logic [31:0] br_target,
   output logic [31:0] j_target
);

   assign pc_plus4  = pc + 32'd4;
   // Word offset becomes a byte offset; the sum wraps modulo 2^32.
   assign br_target = pc_plus4 + (branch_off << 2);
   assign j_target  = {pc_plus4[31:28], jump_idx, 2'b00};

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner with boot FSM and fixed-priority next-PC select.
// Define PC_SEQ_EXC_EN to build in exc/eret, epc, the TRAP state and misaligned-JR traps.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter logic [31:0] RESET_VEC = DEF_RESET_VEC,
   parameter logic [31:0] EXC_VEC   = DEF_EXC_VEC,
   parameter int          BOOT_CYC  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_off,
   input  logic        jump,
   input  logic [25:0] jump_idx,
   input  logic        jr,
   input  logic [31:0] jr_addr,
   input  logic        exc,
   input  logic        eret,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        pc_valid,
   output logic [31:0] epc,
   output logic        misalign
);

   localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYC - 1);

   state_t      state_reg;
   logic [3:0]  boot_cnt_reg;
   logic [31:0] pc_reg;
   logic        pc_valid_reg;
   logic [31:0] br_target;
   logic [31:0] j_target;
   logic        jr_bad;
   logic        exc_req;
   logic        eret_req;
   src_t        sel;

   pc_target_calc u_calc (
      .pc        (pc_reg),
      .branch_off(branch_off),
      .jump_idx  (jump_idx),
      .pc_plus4  (pc_plus4),
      .br_target (br_target),
      .j_target  (j_target)
   );

   assign jr_bad   = is_misaligned(jr_addr[1:0]);
   assign misalign = (state_reg == RUN) && jr && jr_bad;

`ifdef PC_SEQ_EXC_EN
   logic [31:0] epc_reg;
   assign exc_req  = exc;
   assign eret_req = eret;
   assign epc      = epc_reg;
`else
   logic unused_ok;
   assign exc_req   = 1'b0;
   assign eret_req  = 1'b0;
   assign epc       = 32'd0;
   assign unused_ok = &{1'b0, exc, eret, EXC_VEC};
`endif

   always_comb begin
      sel = SEQ;
      if (exc_req)           sel = EXC;
      else if (eret_req)     sel = ERET;
`ifdef PC_SEQ_EXC_EN
      else if (jr)           sel = jr_bad ? EXC : JR;
`else
      else if (jr)           sel = JR;
`endif
      else if (jump)         sel = J;
      else if (branch_taken) sel = BR;
      else if (stall)        sel = HOLD;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg    <= BOOT;
         boot_cnt_reg <= 4'd0;
         pc_reg       <= RESET_VEC;
         pc_valid_reg <= 1'b0;
`ifdef PC_SEQ_EXC_EN
         epc_reg      <= 32'd0;
`endif
      end else begin
         case (state_reg)
            BOOT: begin
               if (boot_cnt_reg == BOOT_LAST) begin
                  state_reg    <= RUN;
                  pc_valid_reg <= 1'b1;
               end else begin
                  boot_cnt_reg <= boot_cnt_reg + 4'd1;
               end
            end
            RUN: begin
               case (sel)
                  SEQ:  pc_reg <= pc_plus4;
                  BR:   pc_reg <= br_target;
                  J:    pc_reg <= j_target;
                  // Low bits are dropped so a misaligned target still fetches a word.
                  JR:   pc_reg <= {jr_addr[31:2], 2'b00};
`ifdef PC_SEQ_EXC_EN
                  EXC: begin
                     epc_reg      <= pc_reg;
                     pc_reg       <= EXC_VEC;
                     state_reg    <= TRAP;
                     pc_valid_reg <= 1'b0;
                  end
                  ERET: pc_reg <= epc_reg;
`endif
                  default: pc_reg <= pc_reg;
               endcase
            end
`ifdef PC_SEQ_EXC_EN
            TRAP: begin
               state_reg    <= RUN;
               pc_valid_reg <= 1'b1;
            end
`endif
            default: state_reg <= BOOT;
         endcase
      end
   end

   assign pc       = pc_reg;
   assign pc_valid = pc_valid_reg;

endmodule
